// File: rtl/icache_loader_pkg.sv
// Shared types and widths for the icache loader, fetch and icache blocks.
// ICACHE_LOADER_CHECKSUM_EN adds the CSUM state to the loader encoding.
package icache_pkg;

  localparam int BYTE_W  = 8;
  localparam int HALF_W  = 16;
  localparam int INDEX_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_WRITE,
`ifdef ICACHE_LOADER_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE
  } state_t;

endpackage

// File: rtl/icache_loader_if.sv
// Byte stream in and icache write port out of the loader.
interface icache_loader_if;
  import icache_pkg::*;

  logic               byte_valid;
  logic [BYTE_W-1:0]  byte_data;
  logic               byte_ready;
  logic               wr_en;
  logic [INDEX_W-1:0] wr_index;
  logic [HALF_W-1:0]  wr_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_index, wr_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_index, wr_data
  );

endinterface

// File: rtl/icache_loader_halfword_packer.sv
// Little-endian assembly of two stream bytes into one Thumb halfword.
module halfword_packer
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_lo,
  input  logic              load_hi,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [HALF_W-1:0] halfword
);

  always_ff @(posedge clk) begin
    if (rst) begin
      halfword <= '0;
    end else begin
      if (load_lo) halfword[7:0]  <= byte_in;
      if (load_hi) halfword[15:8] <= byte_in;
    end
  end

endmodule

// File: rtl/icache_loader.sv
// Fills icache storage from a byte stream, holding fetch off while loading.
// ICACHE_LOADER_CHECKSUM_EN adds a trailing checksum byte and csum_err output.
//
// state | meaning
// IDLE  | waiting for start
// LOW   | accepting low byte of the halfword
// HIGH  | accepting high byte of the halfword
// WRITE | icache write strobe, advance index
// CSUM  | accepting checksum byte (checksum build only)
// DONE  | one-cycle completion pulse
module icache_loader
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int BASE_INDEX = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ADDR_W:0] length,
  icache_loader_if.slave  bus,
  output logic            busy,
  output logic            hold_fetch,
  output logic            done
`ifdef ICACHE_LOADER_CHECKSUM_EN
  ,
  output logic            csum_err
`endif
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

`ifdef ICACHE_LOADER_CHECKSUM_EN
  localparam state_t ST_TAIL = ST_CSUM;
`else
  localparam state_t ST_TAIL = ST_DONE;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W:0]   len_sat;
  logic              start_ok;
  logic              ready;
  logic              write;
  logic              done_pulse;
  logic              xfer;

  assign len_sat  = (length > DEPTH) ? DEPTH : length;
  assign start_ok = (state == ST_IDLE) && start;
  assign xfer     = bus.byte_valid && ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    write      = 1'b0;
    done_pulse = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (len_sat == '0) ? ST_TAIL : ST_LOW;
      end
      ST_LOW: begin
        ready = 1'b1;
        if (bus.byte_valid) state_nxt = ST_HIGH;
      end
      ST_HIGH: begin
        ready = 1'b1;
        if (bus.byte_valid) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        write     = 1'b1;
        state_nxt = (remaining == (ADDR_W+1)'(1)) ? ST_TAIL : ST_LOW;
      end
`ifdef ICACHE_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        ready = 1'b1;
        if (bus.byte_valid) state_nxt = ST_DONE;
      end
`endif
      ST_DONE: begin
        done_pulse = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // offset is cleared in DONE so wr_index rests at BASE_INDEX between loads
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      offset    <= '0;
    end else if (start_ok) begin
      remaining <= len_sat;
      offset    <= '0;
    end else if (state == ST_WRITE) begin
      remaining <= remaining - (ADDR_W+1)'(1);
      offset    <= offset + ADDR_W'(1);
    end else if (state == ST_DONE) begin
      offset    <= '0;
    end
  end

  halfword_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .load_lo  ((state == ST_LOW)  && xfer),
    .load_hi  ((state == ST_HIGH) && xfer),
    .byte_in  (bus.byte_data),
    .halfword (bus.wr_data)
  );

`ifdef ICACHE_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_acc <= '0;
      csum_err <= 1'b0;
    end else if (start_ok) begin
      csum_acc <= '0;
      csum_err <= 1'b0;
    end else if (((state == ST_LOW) || (state == ST_HIGH)) && xfer) begin
      csum_acc <= csum_acc + bus.byte_data;
    end else if ((state == ST_CSUM) && xfer) begin
      csum_err <= (bus.byte_data != csum_acc);
    end
  end
`endif

  assign bus.byte_ready = ready;
  assign bus.wr_en      = write;
  assign bus.wr_index   = INDEX_W'(BASE_INDEX) + INDEX_W'(offset);
  assign busy           = (state != ST_IDLE);
  assign hold_fetch     = busy;
  assign done           = done_pulse;

endmodule

// File: doc/icache_loader.md
Name: icache_loader

Overview:
- Writer side of the instruction cache: it fills the icache storage that the fetch/icache path later reads.
- It takes a byte stream over a valid/ready handshake and packs the bytes little-endian into 16-bit Thumb halfwords.
- Each halfword goes to the icache write port at consecutive indices.
- While a load is in progress it holds fetch off via the icache not_enable input.

Parameters:
- ADDR_W, 8, icache index width; depth is 2^ADDR_W halfwords.
- BASE_INDEX, 0, first icache index written by a load.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE.
- length  in  ADDR_W+1  number of halfwords to load; sampled with start.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  icache write strobe.
- wr_index  out  32  icache write index.
- wr_data  out  16  halfword to write.
- busy  out  1  load in progress.
- hold_fetch  out  1  drives icache not_enable; equals busy.
- done  out  1  one-cycle pulse when a load completes.

Behaviour:
- Transfer rule: a byte transfers on a rising edge with byte_valid && byte_ready. byte_valid may change freely when no transfer occurs.
- Reset: state=IDLE; byte_ready, wr_en, busy, hold_fetch, done = 0; wr_index = BASE_INDEX; wr_data = 0; internal remaining count = 0, offset = 0.
- Applies in any state, including mid-load. A partially written image is not rolled back.
- Length: length > 2^ADDR_W saturates to 2^ADDR_W. Internal offset is ADDR_W bits. wr_index = BASE_INDEX + offset, zero-extended; no wrap occurs within one load.
- IDLE:
  - start with length=0 -> DONE next cycle (done pulse, no writes).
  - start with length>0 -> LOW next cycle; busy and hold_fetch rise on that edge.
  - start in any other state is ignored.
- LOW: byte_ready=1; on transfer latch wr_data[7:0] -> HIGH.
- HIGH: byte_ready=1; on transfer latch wr_data[15:8] -> WRITE.
- WRITE:
  - byte_ready=0; wr_en=1 for exactly this cycle; wr_index and wr_data stable.
  - On exit: offset+1, remaining-1.
  - If remaining was 1 -> DONE, else -> LOW.
- DONE: done=1 for one cycle; busy and hold_fetch drop on the exit edge; -> IDLE. wr_index returns to BASE_INDEX.
- Latency: 3 cycles per halfword with a continuously valid source (LOW, HIGH, WRITE). The first write occurs 3 cycles after the start edge.
- Source stalls: byte_valid low stalls in LOW or HIGH indefinitely, with no timeout.

Optional Feature:
- Macro ICACHE_LOADER_CHECKSUM_EN.
- When defined:
  - An extra output csum_err (1 bit) and state CSUM after the last WRITE.
  - CSUM accepts one byte and compares it with the mod-256 sum of all payload bytes.
  - csum_err is set on mismatch and held until the next accepted start or rst. Then -> DONE.
  - For length=0 the expected sum is 0x00 and one checksum byte is still consumed.
- When undefined: no port, no state, and behaviour is exactly as above.

Decomposition:
- Package icache_pkg holds:
  - the state encoding (IDLE, LOW, HIGH, WRITE, CSUM, DONE);
  - the 16-bit halfword width;
  - the 32-bit index width shared with fetch and icache.
- One sub-module, halfword_packer: byte-to-halfword assembly with low/high phase. The FSM and counters stay in icache_loader.

Test Plan:
- Basic load: rst, start with length=2, bytes 0x34,0x12,0x78,0x56 continuously valid.
  - Expected: wr_en at cycles 3 and 6 with (index 0, 0x1234) and (index 1, 0x5678).
  - done pulses at cycle 7; hold_fetch is high cycles 1-7.
- Stalls: same stream with byte_valid low for 4 cycles between bytes 2 and 3.
  - Expected: identical writes, second write delayed by 4 cycles; byte_ready never drops in LOW or HIGH.
- Zero length: start with length=0.
  - Expected: no wr_en, done 1 cycle later, busy pulses for 1 cycle.
- Reset mid-load: rst asserted in HIGH after 3 halfwords written.
  - Expected: next cycle all outputs at reset values.
  - A new start with length=1 writes index BASE_INDEX.
- Ignored start, with BASE_INDEX=16: start during busy is ignored; length=300 with ADDR_W=8 saturates to 256.
  - Expected: last write at index 271, then done.
- With ICACHE_LOADER_CHECKSUM_EN, length=1, bytes 0x01,0x02:
  - checksum byte 0x03 -> csum_err=0;
  - checksum byte 0x04 -> csum_err=1 until the next start.
